// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch requester and
// the data requester. Accepted transactions are tracked in order in a small
// owner FIFO so that each in-order response is routed back to its requester.
// A fetch-cancel pulse marks every outstanding fetch as discarded so that its
// response is consumed silently (used when an exception redirects the PC).
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   inst_req/wr/size/addr/wdata     fetch-side request
//   inst_addr_ok, inst_data_ok      fetch request accepted / response valid
//   inst_rdata                      fetch response data
//   inst_cancel                     discard all outstanding fetch responses
//   data_req/wr/size/addr/wdata     data-side request
//   data_addr_ok, data_data_ok      data request accepted / response valid
//   data_rdata                      data response data
//   m_req/wr/size/addr/wdata        downstream request
//   m_addr_ok, m_data_ok, m_rdata   downstream accept / in-order response
// -----------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // A request that was presented but not yet accepted keeps the port locked
    // to its owner so the downstream sees a stable request.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_t;

    lock_t                  lock_state, lock_next;
    logic                   last_grant;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       wptr, rptr;
    logic [OUTSTANDING-1:0] fifo_owner;
    logic [OUTSTANDING-1:0] fifo_cncl;

    logic full;
    logic any_req;
    logic gnt_owner;
    logic accept;
    logic pop;
    logic head_owner;
    logic head_cncl;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTSTANDING - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    assign full = (count == CNT_W'(OUTSTANDING));

    // Grant selection: a held lock wins, otherwise round-robin on a tie.
    always_comb begin
        gnt_owner = OWN_INST;
        any_req   = inst_req | data_req;
        case (lock_state)
            LOCK_INST: begin
                gnt_owner = OWN_INST;
                any_req   = 1'b1;
            end
            LOCK_DATA: begin
                gnt_owner = OWN_DATA;
                any_req   = 1'b1;
            end
            default: begin
                if (inst_req && data_req)
                    gnt_owner = ~last_grant;
                else if (data_req)
                    gnt_owner = OWN_DATA;
                else
                    gnt_owner = OWN_INST;
            end
        endcase
    end

    // Outputs are gated by reset so they drop the moment reset asserts,
    // even while a requester keeps its request high.
    assign m_req   = !reset && !full && any_req;
    assign m_wr    = (gnt_owner == OWN_DATA) ? data_wr    : inst_wr;
    assign m_size  = (gnt_owner == OWN_DATA) ? data_size  : inst_size;
    assign m_addr  = (gnt_owner == OWN_DATA) ? data_addr  : inst_addr;
    assign m_wdata = (gnt_owner == OWN_DATA) ? data_wdata : inst_wdata;

    assign accept       = m_req && m_addr_ok;
    assign inst_addr_ok = accept && (gnt_owner == OWN_INST);
    assign data_addr_ok = accept && (gnt_owner == OWN_DATA);

    // A fetch popped in the cancel cycle is already stale, so the live cancel
    // pulse suppresses it together with the stored flag.
    assign pop        = !reset && m_data_ok && (count != '0);
    assign head_owner = fifo_owner[rptr];
    assign head_cncl  = fifo_cncl[rptr] | inst_cancel;

    assign data_data_ok = pop && (head_owner == OWN_DATA);
    assign inst_data_ok = pop && (head_owner == OWN_INST) && !head_cncl;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    always_comb begin
        lock_next = lock_state;
        if (accept)
            lock_next = LOCK_NONE;
        else if (m_req)
            lock_next = (gnt_owner == OWN_DATA) ? LOCK_DATA : LOCK_INST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lock_state <= LOCK_NONE;
        else
            lock_state <= lock_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= OWN_INST;
            count      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_owner <= '0;
            fifo_cncl  <= '0;
        end else begin
            if (inst_cancel) begin
                for (int i = 0; i < OUTSTANDING; i++) begin
                    if (fifo_owner[i] == OWN_INST)
                        fifo_cncl[i] <= 1'b1;
                end
            end
            // The push comes after the cancel sweep so it overrides any stale
            // flag in the slot being reused.
            if (accept) begin
                fifo_owner[wptr] <= gnt_owner;
                fifo_cncl[wptr]  <= inst_cancel && (gnt_owner == OWN_INST);
                wptr             <= ptr_inc(wptr);
                last_grant       <= gnt_owner;
            end
            if (pop)
                rptr <= ptr_inc(rptr);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_req_arbiter
//
// Directed bench for sram_req_arbiter (OUTSTANDING=2). Inputs change 1ns after
// each rising edge; combinational outputs are checked 1ns later.
// -----------------------------------------------------------------------------
module tb_sram_req_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr, inst_cancel;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    sram_req_arbiter #(.OUTSTANDING(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_cancel  (inst_cancel),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_in();
        inst_req    = 1'b0;
        inst_wr     = 1'b0;
        inst_size   = 2'd2;
        inst_addr   = 32'h0;
        inst_wdata  = 32'h0;
        inst_cancel = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        m_addr_ok   = 1'b0;
        m_data_ok   = 1'b0;
        m_rdata     = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        clr_in();
        reset     = 1'b1;
        inst_req  = 1'b1;
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        #2;
        chk("rst_m_req",        m_req,        0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        tick();
        reset = 1'b0;
        clr_in();
        tick();

        // ---------------- single fetch ----------------
        inst_req  = 1'b1;
        inst_addr = 32'hbfc00000;
        m_addr_ok = 1'b1;
        settle();
        chk("f1_m_req",        m_req,        1);
        chk("f1_m_addr",       m_addr,       32'hbfc00000);
        chk("f1_inst_addr_ok", inst_addr_ok, 1);
        chk("f1_data_addr_ok", data_addr_ok, 0);
        tick();
        clr_in();
        m_data_ok = 1'b1;
        m_rdata   = 32'h24010001;
        settle();
        chk("f1_inst_data_ok", inst_data_ok, 1);
        chk("f1_inst_rdata",   inst_rdata,   32'h24010001);
        chk("f1_data_data_ok", data_data_ok, 0);
        tick();

        // stray response with nothing outstanding
        clr_in();
        m_data_ok = 1'b1;
        settle();
        chk("empty_inst_data_ok", inst_data_ok, 0);
        chk("empty_data_data_ok", data_data_ok, 0);
        tick();

        // ---------------- round robin: data, inst, data, inst ----------------
        clr_in();
        inst_req   = 1'b1;
        inst_addr  = 32'h00001000;
        data_req   = 1'b1;
        data_addr  = 32'h00002000;
        data_wr    = 1'b1;
        data_wdata = 32'hdeadbeef;
        m_addr_ok  = 1'b1;
        settle();
        chk("rr0_m_addr",       m_addr,       32'h00002000);
        chk("rr0_data_addr_ok", data_addr_ok, 1);
        chk("rr0_inst_addr_ok", inst_addr_ok, 0);
        chk("rr0_m_wr",         m_wr,         1);
        chk("rr0_m_wdata",      m_wdata,      32'hdeadbeef);
        tick();
        m_data_ok = 1'b1;
        m_rdata   = 32'h11111111;
        settle();
        chk("rr1_m_addr",       m_addr,       32'h00001000);
        chk("rr1_inst_addr_ok", inst_addr_ok, 1);
        chk("rr1_m_wr",         m_wr,         0);
        chk("rr1_data_data_ok", data_data_ok, 1);
        chk("rr1_data_rdata",   data_rdata,   32'h11111111);
        tick();
        m_rdata = 32'h22222222;
        settle();
        chk("rr2_m_addr",       m_addr,       32'h00002000);
        chk("rr2_data_addr_ok", data_addr_ok, 1);
        chk("rr2_inst_data_ok", inst_data_ok, 1);
        chk("rr2_data_data_ok", data_data_ok, 0);
        tick();
        m_rdata = 32'h33333333;
        settle();
        chk("rr3_m_addr",       m_addr,       32'h00001000);
        chk("rr3_inst_addr_ok", inst_addr_ok, 1);
        chk("rr3_data_data_ok", data_data_ok, 1);
        tick();
        clr_in();
        m_data_ok = 1'b1;
        m_rdata   = 32'h44444444;
        settle();
        chk("rr4_inst_data_ok", inst_data_ok, 1);
        chk("rr4_inst_rdata",   inst_rdata,   32'h44444444);
        tick();

        // ---------------- lone data transaction (last grant -> data) ----------------
        clr_in();
        data_req  = 1'b1;
        data_addr = 32'h80000000;
        m_addr_ok = 1'b1;
        settle();
        chk("d1_data_addr_ok", data_addr_ok, 1);
        tick();
        clr_in();
        m_data_ok = 1'b1;
        m_rdata   = 32'h55aa55aa;
        settle();
        chk("d1_data_data_ok", data_data_ok, 1);
        chk("d1_inst_data_ok", inst_data_ok, 0);
        tick();

        // ---------------- lock held against a competing fetch ----------------
        clr_in();
        data_req  = 1'b1;
        data_addr = 32'h80000010;
        settle();
        chk("lk0_m_req",  m_req,  1);
        chk("lk0_m_addr", m_addr, 32'h80000010);
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'hbfc00040;
        settle();
        chk("lk1_m_addr",       m_addr,       32'h80000010);
        chk("lk1_inst_addr_ok", inst_addr_ok, 0);
        tick();
        settle();
        chk("lk2_m_addr", m_addr, 32'h80000010);
        tick();
        m_addr_ok = 1'b1;
        settle();
        chk("lk3_m_addr",       m_addr,       32'h80000010);
        chk("lk3_data_addr_ok", data_addr_ok, 1);
        chk("lk3_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 1'b0;
        settle();
        chk("lk4_m_addr",       m_addr,       32'hbfc00040);
        chk("lk4_inst_addr_ok", inst_addr_ok, 1);
        tick();
        clr_in();
        m_data_ok = 1'b1;
        settle();
        chk("lk5_data_data_ok", data_data_ok, 1);
        tick();
        settle();
        chk("lk6_inst_data_ok", inst_data_ok, 1);
        tick();

        // ---------------- full: two fetches outstanding ----------------
        clr_in();
        inst_req  = 1'b1;
        inst_addr = 32'h00000100;
        m_addr_ok = 1'b1;
        settle();
        chk("fu0_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h00000104;
        settle();
        chk("fu1_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h00000108;
        settle();
        chk("fu2_m_req", m_req, 0);
        tick();
        m_data_ok = 1'b1;
        settle();
        chk("fu3_m_req_no_bypass", m_req,        0);
        chk("fu3_inst_addr_ok",    inst_addr_ok, 0);
        chk("fu3_inst_data_ok",    inst_data_ok, 1);
        tick();
        m_data_ok = 1'b0;
        settle();
        chk("fu4_m_req",        m_req,        1);
        chk("fu4_inst_addr_ok", inst_addr_ok, 1);
        tick();
        clr_in();
        m_data_ok = 1'b1;
        settle();
        chk("fu5_inst_data_ok", inst_data_ok, 1);
        tick();
        settle();
        chk("fu6_inst_data_ok", inst_data_ok, 1);
        tick();

        // ---------------- cancel ----------------
        clr_in();
        inst_req  = 1'b1;
        inst_addr = 32'h00000200;
        m_addr_ok = 1'b1;
        settle();
        chk("cx0_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req  = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h00000300;
        settle();
        chk("cx1_data_addr_ok", data_addr_ok, 1);
        tick();
        data_req    = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h00000400;
        m_data_ok   = 1'b1;
        inst_cancel = 1'b1;
        settle();
        chk("cx2_m_req",        m_req,        0);
        chk("cx2_inst_data_ok", inst_data_ok, 0);
        chk("cx2_data_data_ok", data_data_ok, 0);
        tick();
        m_data_ok = 1'b0;
        settle();
        chk("cx3_inst_addr_ok", inst_addr_ok, 1);
        tick();
        clr_in();
        m_data_ok = 1'b1;
        m_rdata   = 32'hb0b0b0b0;
        settle();
        chk("cx4_data_data_ok", data_data_ok, 1);
        chk("cx4_data_rdata",   data_rdata,   32'hb0b0b0b0);
        chk("cx4_inst_data_ok", inst_data_ok, 0);
        tick();
        settle();
        chk("cx5_inst_data_ok", inst_data_ok, 0);
        chk("cx5_data_data_ok", data_data_ok, 0);
        tick();

        // ---------------- async reset with two outstanding ----------------
        clr_in();
        inst_req  = 1'b1;
        inst_addr = 32'h00000500;
        m_addr_ok = 1'b1;
        settle();
        chk("rs0_inst_addr_ok", inst_addr_ok, 1);
        tick();
        settle();
        chk("rs1_inst_addr_ok", inst_addr_ok, 1);
        tick();
        settle();
        chk("rs2_m_req_full", m_req, 0);
        #1;
        reset     = 1'b1;
        m_data_ok = 1'b1;
        #1;
        chk("rs3_m_req",        m_req,        0);
        chk("rs3_inst_addr_ok", inst_addr_ok, 0);
        chk("rs3_inst_data_ok", inst_data_ok, 0);
        tick();
        reset     = 1'b0;
        inst_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        settle();
        chk("rs4_inst_data_ok", inst_data_ok, 0);
        chk("rs4_data_data_ok", data_data_ok, 0);
        tick();
        m_data_ok = 1'b0;
        inst_req  = 1'b1;
        settle();
        chk("rs5_m_req", m_req, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stages).
- Tracks in-order outstanding transactions and routes each response back to its owner.
- Supports cancelling in-flight fetches when an exception redirects the PC (handle_ex).
- Sits between the CPU core and the memory bridge.

Parameters:
OUTSTANDING, 2, maximum accepted-but-unanswered transactions (depth of owner FIFO, power of 2, >=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
inst_req  in  1  fetch request valid
inst_wr  in  1  fetch write flag (expected 0; forwarded unchanged)
inst_size  in  2  access size (0=byte,1=half,2=word)
inst_addr  in  32  fetch address
inst_wdata  in  32  fetch write data
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid this cycle
inst_rdata  out  32  fetch response data
inst_cancel  in  1  one-cycle pulse: discard all outstanding fetch responses
data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data-side request, same meaning as inst_*
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data response data
m_req  out  1  downstream request
m_wr  out  1  downstream write
m_size  out  2  downstream size
m_addr  out  32  downstream address
m_wdata  out  32  downstream write data
m_addr_ok  in  1  downstream accepted request
m_data_ok  in  1  downstream response valid (in order)
m_rdata  in  32  downstream response data

Behaviour:
- Reset (async): m_req=0, all addr_ok/data_ok=0, FIFO empty (count=0), lock=0, last_grant=inst (so data wins the first tie).
- full = (count==OUTSTANDING). m_req = !full && (lock || inst_req || data_req).
- Selection when not locked:
  - Only one requester active: grant that requester.
  - Both active: grant the one not in last_grant (round-robin).
- Lock:
  - If m_req=1 and m_addr_ok=0, latch the granted owner into a lock register.
  - While locked, m_req, m_wr, m_size, m_addr and m_wdata come from the locked owner's live inputs. Requesters must hold their request stable until addr_ok.
  - The lock clears on m_addr_ok.
- Handshake:
  - On m_req && m_addr_ok, pulse the owner's *_addr_ok combinationally in the same cycle.
  - In the same cycle, push {owner, cancelled=0} into the FIFO, count+1, and set last_grant=owner.
  - The non-granted *_addr_ok stays 0.
- full blocks acceptance even if a pop occurs the same cycle (no bypass). m_req drops to 0 while full; a lock held over from before full persists but m_req is still 0.
- Response:
  - On m_data_ok with count>0, pop the head and count-1.
  - Head owner=data: data_data_ok=1.
  - Head owner=inst and not cancelled: inst_data_ok=1.
  - Cancelled head: popped silently, no data_ok.
  - inst_rdata and data_rdata are both driven with m_rdata (qualified by data_ok).
  - Response latency through the block is 0 cycles (combinational).
- m_data_ok with count==0: ignored, count stays 0, no data_ok pulses.
- Simultaneous push and pop: count unchanged, both actions take effect.
- inst_cancel:
  - Sets cancelled on every stored inst entry, including one popped that cycle (its data_ok is suppressed) and one pushed that cycle.
  - Data entries are unaffected.
  - inst_addr_ok is still pulsed for a request accepted in the cancel cycle.
- FIFO pointers wrap modulo OUTSTANDING. count width is clog2(OUTSTANDING)+1.
- Reset mid-transaction: all state is discarded immediately and later m_data_ok is treated as count==0.

Test Plan:
- Single fetch: inst_req=1, addr=0xbfc00000, m_addr_ok=1 same cycle -> inst_addr_ok=1, m_addr=0xbfc00000. Next cycle m_data_ok=1, m_rdata=0x24010001 -> inst_data_ok=1, inst_rdata=0x24010001, data_data_ok=0.
- Contention round-robin: inst_req and data_req both held, m_addr_ok=1 every cycle, responses returned -> grant order data, inst, data, inst. m_addr alternates between the data and inst addresses.
- Lock: data_req at 0x80000010 with m_addr_ok=0 for 3 cycles, inst_req rises in cycle 2 -> m_addr stays 0x80000010 until m_addr_ok. Then data_addr_ok=1 and inst is granted the next cycle.
- Full (OUTSTANDING=2): two inst requests accepted, no m_data_ok -> m_req=0 with inst_req still high. After one m_data_ok, m_req=1 again the following cycle.
- Cancel: inst A, data B, inst C accepted, then inst_cancel pulse, then 3 m_data_ok pulses -> only data_data_ok for B. No inst_data_ok and count returns to 0.
- Async reset with 2 outstanding: reset asserted mid-cycle -> m_req and all ok outputs are 0 immediately. A subsequent m_data_ok produces no data_ok.
